// File: rtl/nibble_addsub_seq.sv
// rtl/nibble_addsub_seq.sv - nibble-serial adder/subtractor sequencing an external 4-bit ripple-carry adder
// Subtract support is compiled in only when ADDSUB_SUB_EN is defined.
module nibble_addsub_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic [3:0]   rca_a,
  output logic [3:0]   rca_b,
  output logic         rca_c0,
  input  logic [3:0]   rca_s,
  input  logic         rca_c4
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  opa_q, opb_q, result_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q, cout_q, ovf_q, busy_q, done_q;

  logic          sub_d;
  logic [W-1:0]  opb_d;
  logic          run;

`ifdef ADDSUB_SUB_EN
  assign sub_d = op;
  assign opb_d = op ? ~opb : opb;
`else
  // Add-only build: op is accepted on the port but has no effect.
  assign sub_d = 1'b0 & op;
  assign opb_d = opb;
`endif

  assign run    = (state_q == S_RUN);
  assign rca_a  = run ? opa_q[{cnt_q, 2'b00} +: 4] : 4'h0;
  assign rca_b  = run ? opb_q[{cnt_q, 2'b00} +: 4] : 4'h0;
  assign rca_c0 = run ? carry_q : 1'b0;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            opa_q    <= opa;
            opb_q    <= opb_d;
            carry_q  <= sub_d;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
          end
        end
        S_RUN: begin
          result_q[{cnt_q, 2'b00} +: 4] <= rca_s;
          carry_q <= rca_c4;
          // Carry into the MSB differs from carry out exactly on signed overflow.
          if (cnt_q == CW'(NIBBLES - 1)) begin
            cout_q  <= rca_c4;
            ovf_q   <= rca_c4 ^ (rca_a[3] ^ rca_b[3] ^ rca_s[3]);
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// tb/tb_nibble_addsub_seq.sv - scoreboard bench for nibble_addsub_seq with an arithmetic reference model
// Honours ADDSUB_SUB_EN the same way as the design.
module tb_nibble_addsub_seq;
  localparam int N = 4;
  localparam int W = 4 * N;
  localparam longint TWO_W = 64'd1 << W;
  localparam longint HALF  = 64'd1 << (W - 1);
`ifdef ADDSUB_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] opa = '0, opb = '0;
  logic         busy, done, cout, ovf, rca_c0, rca_c4;
  logic [W-1:0] result;
  logic [3:0]   rca_a, rca_b, rca_s;

  // External 4-bit adder, combinational
  assign {rca_c4, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'b0, rca_c0};

  nibble_addsub_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .rca_a(rca_a), .rca_b(rca_b), .rca_c0(rca_c0), .rca_s(rca_s), .rca_c4(rca_c4)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint a;
    longint b_eff;
    longint c0;
    longint res;
    longint co;
    longint ov;
    int     cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   run_k = 0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input longint a, input longint b, input bit o, input int c);
    exp_t   r;
    bit     sub;
    longint sa, sb, sr, full;
    sub = SUB_EN && o;
    sa  = (a >= HALF) ? a - TWO_W : a;
    sb  = (b >= HALF) ? b - TWO_W : b;
    if (sub) begin
      sr   = sa - sb;
      full = a - b;
      r.co = (a >= b) ? 1 : 0;
    end else begin
      sr   = sa + sb;
      full = a + b;
      r.co = (full >= TWO_W) ? 1 : 0;
    end
    r.res   = full & (TWO_W - 1);
    r.ov    = (sr >= HALF || sr < -HALF) ? 1 : 0;
    r.a     = a;
    r.b_eff = sub ? (~b & (TWO_W - 1)) : b;
    r.c0    = sub ? 1 : 0;
    r.cyc   = c;
    return r;
  endfunction

  // Carry into nibble k: overflow of the lower 4k bits of the effective operands
  function automatic longint carry_in(input exp_t x, input int k);
    longint mask;
    mask = (64'd1 << (4 * k)) - 1;
    return (((x.a & mask) + (x.b_eff & mask) + x.c0) >> (4 * k)) & 1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", {busy, done, cout, ovf, rca_c0, rca_a, rca_b, result}, 0);
      run_k = 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("cout", cout, e.co);
        chk("ovf", ovf, e.ov);
        chk("latency", cyc - e.cyc, N + 1);
        chk("run_cycles", run_k, N);
      end
      run_k = 0;
    end else if (busy) begin
      if (exp_q.size() == 0 || run_k >= N) begin
        chk("unexpected_run", 1, 0);
      end else begin
        e = exp_q[0];
        chk("rca_a", rca_a, (e.a >> (4 * run_k)) & 15);
        chk("rca_b", rca_b, (e.b_eff >> (4 * run_k)) & 15);
        chk("rca_c0", rca_c0, carry_in(e, run_k));
      end
      run_k++;
    end else begin
      chk("idle_rca_zero", {rca_a, rca_b, rca_c0}, 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy || exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL wait_idle timeout busy=%0b pending=%0d expected idle", busy, exp_q.size());
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit o, input bit noise);
    int n = 0;
    wait_idle();
    exp_q.push_back(model(a, b, o, cyc));
    opa = a; opb = b; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (noise) begin
      while (busy && n < 50) begin
        start = 1'($urandom_range(0, 1));
        opa   = W'($urandom);
        opb   = W'($urandom);
        op    = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      start = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b1);
    do_op(16'h0000, 16'h0001, 1'b1, 1'b1);

    // Abort in the second RUN cycle
    wait_idle();
    exp_q.push_back(model(16'hABCD, 16'h1111, 1'b0, cyc));
    opa = 16'hABCD; opb = 16'h1111; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    wait_idle();
    repeat (3) @(negedge clk);
    chk("pending_at_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
